// File: rtl/pwm2distance_decoder.sv
// pwm2distance_decoder: recovers distance (high time) and period of a PWM line in enable ticks, flags a stuck line.
// Optional PWM_DECODE_AVG_EN: distance is the mean of 4 consecutive clipped high counts.
module pwm2distance_decoder #(
  parameter int WIDTH = 13,
  parameter int MAX_COUNT = 3000,
  parameter int TIMEOUT = 6002,
  parameter int INVERT = 0,
  localparam int PW = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] distance,
  output logic [PW-1:0]    period,
  output logic             valid,
  output logic             stuck
);
  typedef enum logic {WAIT_RISE, MEAS} state_t;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
  localparam logic [PW-1:0] TMO = PW'(TIMEOUT);
  state_t state, state_n;
  logic [1:0] sync;
  logic pwm_s, pwm_d, rise, tmo, valid_n, stuck_n;
  logic [PW-1:0] per_cnt, per_n, per_inc, period_n;
  logic [WIDTH-1:0] hi_cnt, hi_n, hi_inc, clip, distance_n;
`ifdef PWM_DECODE_AVG_EN
  logic [WIDTH+1:0] acc, acc_n, acc_sum;
  logic [1:0] avg_cnt, avg_cnt_n;
  assign acc_sum = acc + (WIDTH+2)'(clip);
`endif
  assign pwm_s = sync[1] ^ (INVERT != 0);
  assign rise = enable & pwm_s & ~pwm_d;
  assign per_inc = (per_cnt == TMO) ? per_cnt : per_cnt + PW'(1);
  assign hi_inc = (&hi_cnt) ? hi_cnt : hi_cnt + WIDTH'(1);
  // a rise on the timeout tick is a normal measurement, so rise masks tmo
  assign tmo = enable & ~rise & (per_inc == TMO);
  assign clip = (hi_cnt > MAXV) ? MAXV : hi_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= WAIT_RISE;
      sync <= '0;
      pwm_d <= 1'b0;
      per_cnt <= '0;
      hi_cnt <= '0;
      distance <= '0;
      period <= '0;
      valid <= 1'b0;
      stuck <= 1'b0;
    end else begin
      state <= state_n;
      sync <= {sync[0], pwm_in};
      if (enable) pwm_d <= pwm_s;
      per_cnt <= per_n;
      hi_cnt <= hi_n;
      distance <= distance_n;
      period <= period_n;
      valid <= valid_n;
      stuck <= stuck_n;
    end
`ifdef PWM_DECODE_AVG_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      avg_cnt <= '0;
    end else begin
      acc <= acc_n;
      avg_cnt <= avg_cnt_n;
    end
`endif
  always_comb begin
    state_n = state;
    per_n = per_cnt;
    hi_n = hi_cnt;
    distance_n = distance;
    period_n = period;
    valid_n = 1'b0;
    stuck_n = stuck;
`ifdef PWM_DECODE_AVG_EN
    acc_n = acc;
    avg_cnt_n = avg_cnt;
`endif
    if (rise) begin
      state_n = MEAS;
      per_n = PW'(1);
      hi_n = WIDTH'(1);
      stuck_n = 1'b0;
      // the first rise only opens a window; the partial period before it is discarded
      if (state == MEAS) begin
        period_n = per_cnt;
`ifdef PWM_DECODE_AVG_EN
        acc_n = (avg_cnt == 2'd3) ? '0 : acc_sum;
        avg_cnt_n = avg_cnt + 2'd1;
        valid_n = (avg_cnt == 2'd3);
        distance_n = (avg_cnt == 2'd3) ? WIDTH'(acc_sum >> 2) : distance;
`else
        valid_n = 1'b1;
        distance_n = clip;
`endif
      end
    end else if (tmo) begin
      state_n = WAIT_RISE;
      per_n = '0;
      hi_n = '0;
      stuck_n = 1'b1;
      valid_n = ~stuck;
      distance_n = pwm_s ? MAXV : '0;
      period_n = '0;
`ifdef PWM_DECODE_AVG_EN
      acc_n = '0;
      avg_cnt_n = '0;
`endif
    end else if (enable) begin
      per_n = per_inc;
      hi_n = pwm_s ? hi_inc : hi_cnt;
    end
  end
endmodule
